// File: rtl/key_sched_256_ctrl.sv
// AES-256 key-schedule controller: walks words 8..59 through an 8-word window
// and streams the 15 round keys over a valid/ready handshake.

module current_word_gen_256 (
    input  logic [5:0]  i,
    input  logic [31:0] prev_word,
    input  logic [31:0] prev_period_word,
    output logic [31:0] next_word
);
    // Forward S-box; entry b lives at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [7:0]  rcon;
    logic [31:0] temp;

    always_comb begin
        case (i[5:3])
            3'd1:    rcon = 8'h01;
            3'd2:    rcon = 8'h02;
            3'd3:    rcon = 8'h04;
            3'd4:    rcon = 8'h08;
            3'd5:    rcon = 8'h10;
            3'd6:    rcon = 8'h20;
            3'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
        temp = prev_word;
        if (i[2:0] == 3'd0)
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        else if (i[2:0] == 3'd4)
            temp = sub_word(prev_word);
        next_word = temp ^ prev_period_word;
    end
endmodule

module key_sched_256_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         abort,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;

    state_t            state_q, state_d;
    logic [7:0][31:0]  win_q, win_d;      // win_q[0] oldest, win_q[7] newest
    logic [5:0]        i_q, i_d;
    logic [1:0]        gcnt_q, gcnt_d;
    logic [3:0]        rk_index_q, rk_index_d;
    logic              done_q, done_d;
    logic [31:0]       new_word;

    current_word_gen_256 u_gen (
        .i                (i_q),
        .prev_word        (win_q[7]),
        .prev_period_word (win_q[0]),
        .next_word        (new_word)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        i_d        = i_q;
        gcnt_d     = gcnt_q;
        rk_index_d = rk_index_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    for (int k = 0; k < 8; k++)
                        win_d[k] = key_in[255-32*k -: 32];
                    i_d        = 6'd8;
                    gcnt_d     = 2'd0;
                    rk_index_d = 4'd0;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rk_index_q == 4'd14) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (rk_index_q == 4'd0) begin
                        rk_index_d = 4'd1;
                    end else begin
                        rk_index_d = rk_index_q + 4'd1;
                        state_d    = GEN;
                    end
                end
            end
            GEN: begin
                for (int k = 0; k < 7; k++)
                    win_d[k] = win_q[k+1];
                win_d[7] = new_word;
                i_d      = i_q + 6'd1;
                gcnt_d   = gcnt_q + 2'd1;
                if (gcnt_q == 2'd3) begin
                    gcnt_d  = 2'd0;
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any handshake in the same cycle; the window is left as-is.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            i_q        <= '0;
            gcnt_q     <= '0;
            rk_index_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            i_q        <= i_d;
            gcnt_q     <= gcnt_d;
            rk_index_q <= rk_index_d;
            done_q     <= done_d;
        end
    end

    // rk0 is the raw key's first half; every later key is the newest four words.
    assign rk_data   = (rk_index_q == 4'd0) ? {win_q[0], win_q[1], win_q[2], win_q[3]}
                                            : {win_q[4], win_q[5], win_q[6], win_q[7]};
    assign rk_index  = rk_index_q;
    assign rk_valid  = (state_q == EMIT);
    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
endmodule

// File: tb/tb_key_sched_256_ctrl.sv
// Directed bench for key_sched_256_ctrl: FIPS-197 keys, backpressure, abort,
// mid-run reset; expected round keys come from an independent expansion model.

module tb_key_sched_256_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_valid, key_ready, abort;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_valid, rk_ready, busy, done;

    key_sched_256_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .abort(abort), .rk_data(rk_data), .rk_index(rk_index),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int checks = 0, passes = 0, fails = 0;
    int cyc;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes += 1;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from GF(2^8) inverse plus affine map, independent of the RTL table.
    task automatic build_sbox();
        logic [7:0] y;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int z = 1; z < 256; z++)
                if (gmul(8'(x), 8'(z)) == 8'h01) y = 8'(z);
            sb[x] = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic model(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int n = 0; n < 8; n++) w[n] = k[255-32*n -: 32];
        for (int n = 8; n < 60; n++) begin
            t = w[n-1];
            if (n % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (n % 8 == 4) begin
                t = subw(t);
            end
            w[n] = w[n-8] ^ t;
        end
        for (int j = 0; j < 15; j++)
            exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_key(input logic [255:0] k);
        key_in    = k;
        key_valid = 1'b1;
        chk("key_ready_at_start", 128'(key_ready), 128'd1);
        cyc = 0;
        tick();
        key_valid = 1'b0;
    endtask

    // Full schedule; returns in the done cycle with key_valid low.
    task automatic run_sched(input logic [255:0] k, input bit stall, input bit pulse_kv);
        int nxt, stalls, spur, exp_cyc;
        model(k);
        rk_ready = 1'b1;
        start_key(k);
        nxt = 0; stalls = 0; spur = 0;
        while (nxt < 15 && cyc < 400) begin
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_kv) begin
                key_in    = ~k;
                key_valid = (cyc == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (rk_valid) begin
                chk("rk_index", 128'(rk_index), 128'(nxt));
                chk("rk_data", rk_data, exp_rk[nxt]);
                if (rk_ready) begin
                    if (!stall) begin
                        exp_cyc = (nxt < 2) ? nxt + 1 : 7 + 5 * (nxt - 2);
                        chk("rk_time", 128'(cyc), 128'(exp_cyc));
                    end
                    got_rk[nxt] = rk_data;
                    nxt++;
                end else begin
                    stalls++;
                end
            end
            if (done || key_ready) spur++;
            tick();
        end
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        chk("sched_complete", 128'(nxt), 128'd15);
        chk("no_done_or_ready_while_busy", 128'(spur), 128'd0);
        chk("done_cycle", 128'(cyc), 128'(68 + stalls));
        chk("done_pulse", 128'(done), 128'd1);
        chk("key_ready_at_done", 128'(key_ready), 128'd1);
        chk("rk_valid_at_done", 128'(rk_valid), 128'd0);
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b1;
        #2;
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_data", rk_data, 128'd0);
        chk("rst_rk_index", 128'(rk_index), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.3 key, no backpressure
        run_sched(KEY_C3, 1'b0, 1'b0);
        chk("c3_rk0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
        chk("c3_rk1", got_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
        chk("c3_rk2", got_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
        chk("c3_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        tick();
        chk("done_is_one_cycle", 128'(done), 128'd0);

        // FIPS-197 A.3 key
        run_sched(KEY_A3, 1'b0, 1'b0);
        chk("a3_rk2", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("a3_rk14_last_word", 128'(got_rk[14][31:0]), 128'h706c631e);
        tick();

        // random backpressure
        run_sched(KEY_C3, 1'b1, 1'b0);
        chk("stall_c3_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        tick();

        // key_valid noise while busy, then a second key taken in the done cycle
        run_sched(KEY_A3, 1'b0, 1'b1);
        run_sched(KEY_C3, 1'b0, 1'b0);
        tick();

        // abort while generating rk5
        rk_ready = 1'b1;
        start_key(KEY_A3);
        repeat (18) tick();
        chk("gen_busy", 128'(busy), 128'd1);
        chk("gen_rk_valid", 128'(rk_valid), 128'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_gen_rk_valid", 128'(rk_valid), 128'd0);
        chk("abort_gen_key_ready", 128'(key_ready), 128'd1);
        chk("abort_gen_done", 128'(done), 128'd0);
        repeat (3) begin
            tick();
            chk("abort_gen_quiet", 128'({rk_valid, done, busy}), 128'd0);
        end

        // abort in the same cycle as the rk14 handshake
        start_key(KEY_C3);
        repeat (66) tick();
        chk("pre_abort_rk_index", 128'(rk_index), 128'd14);
        chk("pre_abort_rk_valid", 128'(rk_valid), 128'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_rk14_done", 128'(done), 128'd0);
        chk("abort_rk14_key_ready", 128'(key_ready), 128'd1);
        chk("abort_rk14_rk_valid", 128'(rk_valid), 128'd0);
        tick();
        chk("abort_rk14_no_late_done", 128'(done), 128'd0);

        // asynchronous reset while rk9 is being offered
        start_key(KEY_A3);
        repeat (41) tick();
        rk_ready = 1'b0;
        chk("pre_rst_rk_index", 128'(rk_index), 128'd9);
        chk("pre_rst_rk_valid", 128'(rk_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
        chk("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_rk_data", rk_data, 128'd0);
        chk("mid_rst_rk_index", 128'(rk_index), 128'd0);
        chk("mid_rst_busy_done", 128'({busy, done}), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rk_ready = 1'b1;
        tick(); tick();
        chk("post_rst_quiet", 128'({rk_valid, done, busy}), 128'd0);
        run_sched(KEY_A3, 1'b0, 1'b0);
        chk("rekey_a3_rk2", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
